wbu: RTL and testbench

WBU -- requirements
Module: wbu

---
 rtl/wbu.sv | 132 +++++++++++++
 tb/tb_wbu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// Writeback unit: arbitrates ALU and LSU results into one register-file write port.
// Optional WBU_RETIRE_CNT_EN adds a 64-bit count of retired entries.
module wbu #(
  parameter bit PRIO_LSU = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_rdata,
  input  logic [2:0]  lsu_addr_lo,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        busy
`ifdef WBU_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_cnt
`endif
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 64;

  logic          alu_v, lsu_v, ptr;
  logic [RW-1:0] alu_rd_q, lsu_rd_q;
  logic [DW-1:0] alu_d, lsu_d;

  logic          grant_alu_c, grant_lsu_c;
  logic          alu_acc_c, lsu_acc_c;
  logic          alu_v_n, lsu_v_n, ptr_n, rf_wen_n;
  logic [RW-1:0] rf_waddr_n;
  logic [DW-1:0] rf_wdata_n;
  logic [2:0]    off_c;
  logic [DW-1:0] shifted_c, load_c;

  // Load extraction: align the offset down to the access size, then extend.
  always_comb begin
    off_c     = 3'd0;
    load_c    = '0;
    case (lsu_size)
      2'b00:   off_c = lsu_addr_lo;
      2'b01:   off_c = {lsu_addr_lo[2:1], 1'b0};
      2'b10:   off_c = {lsu_addr_lo[2], 2'b00};
      default: off_c = 3'd0;
    endcase
    shifted_c = lsu_rdata >> {off_c, 3'b000};
    case (lsu_size)
      2'b00:   load_c = lsu_unsigned ? {56'd0, shifted_c[7:0]}
                                     : {{56{shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   load_c = lsu_unsigned ? {48'd0, shifted_c[15:0]}
                                     : {{48{shifted_c[15]}}, shifted_c[15:0]};
      2'b10:   load_c = lsu_unsigned ? {32'd0, shifted_c[31:0]}
                                     : {{32{shifted_c[31]}}, shifted_c[31:0]};
      default: load_c = shifted_c;
    endcase
  end

  // Arbitration and next state; ready depends only on held state and rst.
  always_comb begin
    grant_alu_c = alu_v && (!lsu_v || !ptr);
    grant_lsu_c = lsu_v && (!alu_v || ptr);
    alu_ready   = rst && (!alu_v || grant_alu_c);
    lsu_ready   = rst && (!lsu_v || grant_lsu_c);
    alu_acc_c   = alu_valid && alu_ready;
    lsu_acc_c   = lsu_valid && lsu_ready;
    alu_v_n     = alu_acc_c || (alu_v && !grant_alu_c);
    lsu_v_n     = lsu_acc_c || (lsu_v && !grant_lsu_c);
    ptr_n       = ptr;
    if (alu_v && lsu_v) ptr_n = grant_alu_c;
    rf_wen_n    = 1'b0;
    rf_waddr_n  = rf_waddr;
    rf_wdata_n  = rf_wdata;
    if (grant_lsu_c) begin
      rf_wen_n   = (lsu_rd_q != '0);
      rf_waddr_n = lsu_rd_q;
      rf_wdata_n = lsu_d;
    end else if (grant_alu_c) begin
      rf_wen_n   = (alu_rd_q != '0);
      rf_waddr_n = alu_rd_q;
      rf_wdata_n = alu_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_v    <= 1'b0;
      lsu_v    <= 1'b0;
      alu_rd_q <= '0;
      lsu_rd_q <= '0;
      alu_d    <= '0;
      lsu_d    <= '0;
      ptr      <= PRIO_LSU;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= 1'b0;
    end else begin
      alu_v    <= alu_v_n;
      lsu_v    <= lsu_v_n;
      ptr      <= ptr_n;
      rf_wen   <= rf_wen_n;
      rf_waddr <= rf_waddr_n;
      rf_wdata <= rf_wdata_n;
      busy     <= alu_v_n || lsu_v_n || rf_wen_n;
      if (alu_acc_c) begin
        alu_rd_q <= alu_rd;
        alu_d    <= alu_data;
      end
      if (lsu_acc_c) begin
        lsu_rd_q <= lsu_rd;
        lsu_d    <= load_c;
      end
    end
  end

`ifdef WBU_RETIRE_CNT_EN
  // Counts every granted entry, including rd = 0 retirements.
  always_ff @(posedge clk) begin
    if (!rst) retire_cnt <= '0;
    else if (grant_alu_c || grant_lsu_c) retire_cnt <= retire_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: reset, ALU/LSU writes, load extension, arbitration, mid-run reset.
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_rdata;
  logic [2:0]  lsu_addr_lo;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        busy;
`ifdef WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
  logic [63:0] cnt_before;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wbu #(.PRIO_LSU(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_addr_lo(lsu_addr_lo), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
`ifdef WBU_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu_load(input string tag, input logic [63:0] rdata, input logic [2:0] lo,
                          input logic [1:0] sz, input logic uns, input logic [63:0] exp);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_rdata = rdata;
    lsu_addr_lo = lo; lsu_size = sz; lsu_unsigned = uns;
    tick();
    lsu_valid = 1'b0;
    tick();
    check({tag, "_wen"}, 64'(rf_wen), 64'd1);
    check({tag, "_data"}, rf_wdata, exp);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_rdata = '0;
    lsu_addr_lo = '0; lsu_size = '0; lsu_unsigned = 1'b0;
    tick(); tick();
    check("rst_wen", 64'(rf_wen), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("idle_alu_ready", 64'(alu_ready), 64'd1);

    // ALU write: 2-cycle latency, one-cycle pulse
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    alu_valid = 1'b0;
    check("alu_n_wen", 64'(rf_wen), 64'd0);
    check("alu_n_busy", 64'(busy), 64'd1);
    tick();
    check("alu_wen", 64'(rf_wen), 64'd1);
    check("alu_waddr", 64'(rf_waddr), 64'd5);
    check("alu_wdata", rf_wdata, 64'h1234);
    tick();
    check("alu_wen_drop", 64'(rf_wen), 64'd0);
    check("alu_idle_busy", 64'(busy), 64'd0);

    // Load extraction
    lsu_load("half_s", 64'h00000000_80FF0000, 3'd2, 2'b01, 1'b0, 64'hFFFFFFFF_FFFF80FF);
    lsu_load("half_u", 64'h00000000_80FF0000, 3'd2, 2'b01, 1'b1, 64'h00000000_000080FF);
    lsu_load("dbl_mis", 64'h12345678_9ABCDEF0, 3'd5, 2'b11, 1'b0, 64'h12345678_9ABCDEF0);
    lsu_load("word_mis", 64'h12345678_9ABCDEF0, 3'd6, 2'b10, 1'b0, 64'h00000000_12345678);
    lsu_load("byte_s3", 64'h12345678_9ABCDEF0, 3'd3, 2'b00, 1'b0, 64'hFFFFFFFF_FFFFFF9A);
    lsu_load("byte_u7", 64'h80000000_00000000, 3'd7, 2'b00, 1'b1, 64'h00000000_00000080);

    // rd = 0 retires without writing
`ifdef WBU_RETIRE_CNT_EN
    cnt_before = retire_cnt;
`endif
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    tick();
    alu_valid = 1'b0;
    tick();
    check("rd0_wen", 64'(rf_wen), 64'd0);
    check("rd0_wdata", rf_wdata, 64'hDEAD);
    check("rd0_ready", 64'(alu_ready), 64'd1);
    check("rd0_busy", 64'(busy), 64'd0);
`ifdef WBU_RETIRE_CNT_EN
    check("rd0_cnt", retire_cnt, cnt_before + 64'd1);
`endif

    // Contention after reset: LSU first, then strict alternation
    rst = 1'b0;
    tick();
    rst = 1'b1;
    begin
      int an = 0, ln = 0, w = 0;
      logic acc_a, acc_l;
      alu_valid = 1'b1; alu_rd = 5'd1;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_size = 2'b11; lsu_unsigned = 1'b1; lsu_addr_lo = 3'd0;
      for (int c = 0; c < 9; c++) begin
        alu_data  = 64'hA000 + 64'(an);
        lsu_rdata = 64'hB000 + 64'(ln);
        #1;
        acc_a = alu_ready;
        acc_l = lsu_ready;
        tick();
        if (acc_a) an++;
        if (acc_l) ln++;
        if (c >= 1) begin
          check("rr_wen", 64'(rf_wen), 64'd1);
          if (w % 2 == 0) begin
            check("rr_lsu_addr", 64'(rf_waddr), 64'd2);
            check("rr_lsu_data", rf_wdata, 64'hB000 + 64'(w / 2));
          end else begin
            check("rr_alu_addr", 64'(rf_waddr), 64'd1);
            check("rr_alu_data", rf_wdata, 64'hA000 + 64'(w / 2));
          end
          w++;
        end
      end
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    check("full_busy", 64'(busy), 64'd1);

    // Mid-run reset discards both held entries
    rst = 1'b0;
    tick();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wen", 64'(rf_wen), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_wen", 64'(rf_wen), 64'd0);
    end
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
